mult32_appx_arb: RTL

MULT32_APPX_ARB -- requirements
Module: mult32_appx_arb

---
 rtl/mult32_appx_arb_if.sv | 40 ++++
 rtl/mult32_appx_arb.sv | 121 ++++++++++++
 2 files changed

// File: rtl/mult32_appx_arb_if.sv
// mult32_appx_arb_if: bundles the signals between the two-requester arbiter, its
// requesters, the shared multiplier datapath and the response consumer.
//   req_valid/req_ready   per-requester handshake (bit i = requester i)
//   req_a0/b0, req_a1/b1  operands of requester 0 / 1
//   req_mode              per-requester mode: 0 = approximate, 1 = exact
//   mul_a/mul_b/mul_vld   issue port to the shared multiplier
//   mul_y_appx/exact      products returned by the multiplier
//   rsp_valid/id/data     one-cycle response pulse, no backpressure
// Modport slave is taken by the arbiter; master is taken by its environment.
interface mult32_appx_arb_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a0;
    logic [31:0] req_b0;
    logic [31:0] req_a1;
    logic [31:0] req_b1;
    logic [1:0]  req_mode;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_vld;
    logic [63:0] mul_y_appx;
    logic [63:0] mul_y_exact;
    logic        rsp_valid;
    logic        rsp_id;
    logic [63:0] rsp_data;

    modport slave (
        input  req_valid, req_a0, req_b0, req_a1, req_b1, req_mode,
        input  mul_y_appx, mul_y_exact,
        output req_ready, mul_a, mul_b, mul_vld,
        output rsp_valid, rsp_id, rsp_data
    );

    modport master (
        output req_valid, req_a0, req_b0, req_a1, req_b1, req_mode,
        output mul_y_appx, mul_y_exact,
        input  req_ready, mul_a, mul_b, mul_vld,
        input  rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/mult32_appx_arb.sv
// mult32_appx_arb: round-robin arbiter sharing one pipelined 32x32 multiplier between
// two requesters. Each granted op carries a tag (valid, id, mode) down a LAT-deep
// pipeline; when the tag reaches the end, the approximate or exact product is
// registered into the response and the matching saturating counter is bumped.
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   en         grant enable; in-flight ops drain while low
//   bus        mult32_appx_arb_if.slave (requests, multiplier port, responses)
//   busy       high while any op is in flight
//   cnt_appx   saturating count of completed approximate ops
//   cnt_exact  saturating count of completed exact ops
module mult32_appx_arb #(
    parameter int unsigned LAT = 2,
    parameter int unsigned CW  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    mult32_appx_arb_if.slave    bus,
    output logic                busy,
    output logic [CW-1:0]       cnt_appx,
    output logic [CW-1:0]       cnt_exact
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic           ptr;
    logic [1:0]     ready;
    logic           grant;
    logic           gnt_id;

    logic [31:0]    mul_a;
    logic [31:0]    mul_b;
    logic           mul_vld;

    logic [LAT-1:0] tag_vld;
    logic [LAT-1:0] tag_id;
    logic [LAT-1:0] tag_mode;

    logic           rsp_valid;
    logic           rsp_id;
    logic [63:0]    rsp_data;

    // Grant: the pointer only breaks ties; a lone requester always wins.
    always_comb begin
        ready = 2'b00;
        if (!rst && en) begin
            if (bus.req_valid == 2'b11) begin
                ready = ptr ? 2'b10 : 2'b01;
            end else begin
                ready = bus.req_valid;
            end
        end
    end

    assign grant  = |ready;
    assign gnt_id = ready[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= 1'b0;
            mul_a     <= 32'd0;
            mul_b     <= 32'd0;
            mul_vld   <= 1'b0;
            tag_vld   <= '0;
            tag_id    <= '0;
            tag_mode  <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= 64'd0;
            cnt_appx  <= '0;
            cnt_exact <= '0;
        end else begin
            mul_vld <= grant;
            if (grant) begin
                ptr   <= ~gnt_id;
                mul_a <= gnt_id ? bus.req_a1 : bus.req_a0;
                mul_b <= gnt_id ? bus.req_b1 : bus.req_b0;
            end

            // Tag stage 0 lines up with mul_vld; the last stage lines up with
            // the cycle in which the datapath presents the product.
            tag_vld[0]  <= grant;
            tag_id[0]   <= gnt_id;
            tag_mode[0] <= bus.req_mode[gnt_id];
            for (int unsigned i = 1; i < LAT; i++) begin
                tag_vld[i]  <= tag_vld[i-1];
                tag_id[i]   <= tag_id[i-1];
                tag_mode[i] <= tag_mode[i-1];
            end

            rsp_valid <= tag_vld[LAT-1];
            if (tag_vld[LAT-1]) begin
                rsp_id   <= tag_id[LAT-1];
                rsp_data <= tag_mode[LAT-1] ? bus.mul_y_exact : bus.mul_y_appx;
                if (tag_mode[LAT-1]) begin
                    if (cnt_exact != CNT_MAX) begin
                        cnt_exact <= cnt_exact + 1'b1;
                    end
                end else begin
                    if (cnt_appx != CNT_MAX) begin
                        cnt_appx <= cnt_appx + 1'b1;
                    end
                end
            end
        end
    end

    // Pulses are masked while rst is high so nothing leaks out in the reset
    // cycle itself, before the synchronous clear has taken effect.
    assign bus.req_ready = ready;
    assign bus.mul_a     = mul_a;
    assign bus.mul_b     = mul_b;
    assign bus.mul_vld   = mul_vld & ~rst;
    assign bus.rsp_valid = rsp_valid & ~rst;
    assign bus.rsp_id    = rsp_id;
    assign bus.rsp_data  = rsp_data;
    assign busy          = ~rst & ((|tag_vld) | mul_vld);

endmodule
